// File: rtl/shift_sequencer_if.sv
// Request/grant/result bundle for shift_sequencer.
// master: the requester side; slave: the sequencer.
interface shift_sequencer_if;
    logic       req0;
    logic       req1;
    logic [7:0] op0;
    logic [7:0] op1;
    logic [3:0] amt0;
    logic [3:0] amt1;
    logic       gnt0;
    logic       gnt1;
    logic       busy;
    logic       done;
    logic       done_id;
    logic [7:0] result;

    modport master (
        output req0, req1, op0, op1, amt0, amt1,
        input  gnt0, gnt1, busy, done, done_id, result
    );

    modport slave (
        input  req0, req1, op0, op1, amt0, amt1,
        output gnt0, gnt1, busy, done, done_id, result
    );
endinterface

// File: rtl/shift_sequencer.sv
// shift_sequencer: two-requester round-robin front end feeding a multi-pass
// left shifter. Each pass moves the data by at most STEP_MAX bits, so a job
// of amount amt takes max(1, ceil(amt/STEP_MAX)) SHIFT cycles plus one DONE.
// Build option: define SHIFT_SEQ_ROTATE_EN to rotate instead of zero-filling.
module shift_sequencer #(
    parameter int STEP_MAX = 7
) (
    input  logic             clk,
    input  logic             rst,
    shift_sequencer_if.slave bus
);

    localparam logic [2:0] STEP_LIM = 3'(STEP_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t     state;

    // Registered control outputs
    logic       gnt0_r;
    logic       gnt1_r;
    logic       busy_r;
    logic       done_r;
    logic       done_id_r;
    logic [7:0] result_r;
    // Requester granted most recently; 1 after reset so requester 0 wins a tie
    logic       last_r;

    // Job registers (captured at grant, not reset)
    logic [7:0] data_q;
    logic [3:0] rem_q;
    logic       id_q;

    // Arbitration result for the current cycle
    logic       win_vld;
    logic       win_id;
    logic [7:0] win_op;
    logic [3:0] win_amt;

    // One pass of the shifter
    logic [2:0] step;
    logic [7:0] data_nx;
    logic [3:0] rem_nx;

    // Bits moved in one pass: the remaining amount, capped at STEP_MAX
    function automatic logic [2:0] step_of(input logic [3:0] rem);
        if (rem > {1'b0, STEP_LIM}) begin
            return STEP_LIM;
        end
        return rem[2:0];
    endfunction

    // Single left pass by s bits (rotate or zero-fill depending on build)
    function automatic logic [7:0] shift_pass(input logic [7:0] d, input logic [2:0] s);
        logic [15:0] w;
`ifdef SHIFT_SEQ_ROTATE_EN
        w = {d, d} << s;
        return w[15:8];
`else
        w = {8'h00, d} << s;
        return w[7:0];
`endif
    endfunction

    // Round-robin pick: sole requester wins, on a tie the one not granted last
    always_comb begin
        win_vld = bus.req0 | bus.req1;
        win_id  = (bus.req0 && bus.req1) ? ~last_r : bus.req1;
        win_op  = win_id ? bus.op1 : bus.op0;
        win_amt = win_id ? bus.amt1 : bus.amt0;
    end

    // Next data/remaining value after applying one pass
    always_comb begin
        step    = step_of(rem_q);
        data_nx = shift_pass(data_q, step);
        rem_nx  = rem_q - {1'b0, step};
    end

    // Control FSM with registered outputs; reset drops any job in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            gnt0_r    <= 1'b0;
            gnt1_r    <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            done_id_r <= 1'b0;
            result_r  <= 8'h00;
            last_r    <= 1'b1;
        end else begin
            gnt0_r <= 1'b0;
            gnt1_r <= 1'b0;
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        gnt0_r <= ~win_id;
                        gnt1_r <= win_id;
                        last_r <= win_id;
                        busy_r <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (rem_nx == 4'd0) begin
                        done_r    <= 1'b1;
                        done_id_r <= id_q;
                        result_r  <= data_nx;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    // Job datapath: capture the winner's operands, then one pass per SHIFT cycle
    always_ff @(posedge clk) begin
        if (state == IDLE && win_vld) begin
            data_q <= win_op;
            rem_q  <= win_amt;
            id_q   <= win_id;
        end else if (state == SHIFT) begin
            data_q <= data_nx;
            rem_q  <= rem_nx;
        end
    end

    assign bus.gnt0    = gnt0_r;
    assign bus.gnt1    = gnt1_r;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.done_id = done_id_r;
    assign bus.result  = result_r;

endmodule
